// File: rtl/inst_pos_bridge.sv
// Posedge fetch bridge: turns held fetch requests into single-word valid/ready reads on the outer IRAM.
// It keeps a one-entry last-word buffer. Define INST_POS_BRIDGE_TIMEOUT_EN to add the WAIT timeout and the DRAIN recovery.
module inst_pos_bridge #(
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
    parameter logic [31:0] ADDR_END       = 32'h0000_0fff,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inst_pos_req_i,
    input  logic [31:0] inst_pos_addr_i,
    output logic        inst_pos_ack_o,
    output logic [31:0] inst_pos_data_o,
    output logic        inst_pos_error_o,
    input  logic        flush_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_addr_o,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rsp_data_i,
    input  logic        mem_rsp_error_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ACK,
        S_DRAIN
    } state_t;

    localparam logic [31:0] ADDR_SPAN = ADDR_END - ADDR_BASE;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_req_addr;
    logic [31:0] r_data;
    logic        r_error;
    logic        r_buf_valid;
    logic [29:0] r_buf_tag;
    logic [31:0] r_buf_data;
    logic        r_flush_pend;
    logic        r_to_drain;

    logic [31:0] w_addr_off;
    logic        w_in_range;
    logic        w_hit;
    logic        w_timeout;
    logic        w_load_miss;
    logic        w_load_ack;
    logic [31:0] w_ack_data;
    logic        w_ack_error;
    logic        w_buf_write;
    logic        w_buf_clear;

    // Offset compare handles ADDR_BASE=0 without a constant-false "below base" test.
    assign w_addr_off = inst_pos_addr_i - ADDR_BASE;
    assign w_in_range = (w_addr_off <= ADDR_SPAN);
    assign w_hit      = r_buf_valid && !flush_i && (r_buf_tag == inst_pos_addr_i[31:2]);

`ifdef INST_POS_BRIDGE_TIMEOUT_EN
    logic [15:0] r_wait_cnt;

    // Held at zero outside WAIT, so it is already clear on every entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wait_cnt <= 16'd0;
        end else if (r_state != S_WAIT) begin
            r_wait_cnt <= 16'd0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_state == S_WAIT) && !mem_rsp_valid_i &&
                       (r_wait_cnt == (TIMEOUT_CYCLES - 16'd1));
`else
    // No counter in this build; the parameter is referenced only to keep its meaning visible.
    assign w_timeout = 1'b0 & (TIMEOUT_CYCLES == 16'd0);
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_load_miss  = 1'b0;
        w_load_ack   = 1'b0;
        w_ack_data   = 32'd0;
        w_ack_error  = 1'b0;
        w_buf_write  = 1'b0;
        w_buf_clear  = flush_i;

        case (r_state)
            S_IDLE: begin
                if (inst_pos_req_i) begin
                    if (!w_in_range) begin
                        w_load_ack   = 1'b1;
                        w_ack_error  = 1'b1;
                        w_next_state = S_ACK;
                    end else if (w_hit) begin
                        w_load_ack   = 1'b1;
                        w_ack_data   = r_buf_data;
                        w_next_state = S_ACK;
                    end else begin
                        w_load_miss  = 1'b1;
                        w_next_state = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready_i) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid_i) begin
                    w_load_ack   = 1'b1;
                    w_ack_data   = mem_rsp_data_i;
                    w_ack_error  = mem_rsp_error_i;
                    w_next_state = S_ACK;
                    if (mem_rsp_error_i) begin
                        w_buf_clear = 1'b1;
                    end else if (!flush_i && !r_flush_pend) begin
                        w_buf_write = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_load_ack   = 1'b1;
                    w_ack_error  = 1'b1;
                    w_next_state = S_ACK;
                end
            end
            S_ACK: begin
                w_next_state = r_to_drain ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (mem_rsp_valid_i) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: the buffer entry is reset along with its valid bit; it is a single word, not a RAM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_req_addr   <= 32'd0;
            r_data       <= 32'd0;
            r_error      <= 1'b0;
            r_buf_valid  <= 1'b0;
            r_buf_tag    <= 30'd0;
            r_buf_data   <= 32'd0;
            r_flush_pend <= 1'b0;
            r_to_drain   <= 1'b0;
        end else begin
            if (w_load_miss) begin
                r_req_addr <= {inst_pos_addr_i[31:2], 2'b00};
            end
            if (w_load_ack) begin
                r_data     <= w_ack_data;
                r_error    <= w_ack_error;
                r_to_drain <= w_timeout;
            end
            if (w_buf_clear) begin
                r_buf_valid <= 1'b0;
            end else if (w_buf_write) begin
                r_buf_valid <= 1'b1;
            end
            if (w_buf_write) begin
                r_buf_tag  <= r_req_addr[31:2];
                r_buf_data <= mem_rsp_data_i;
            end
            // A flush seen while a read is in flight keeps that read's data out of the buffer.
            if (r_state == S_IDLE) begin
                r_flush_pend <= 1'b0;
            end else if (flush_i && (r_state == S_REQ || r_state == S_WAIT)) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    assign inst_pos_ack_o   = (r_state == S_ACK);
    assign inst_pos_data_o  = r_data;
    assign inst_pos_error_o = r_error;
    assign mem_req_valid_o  = (r_state == S_REQ);
    assign mem_req_addr_o   = r_req_addr;

endmodule

// File: tb/tb_inst_pos_bridge.sv
// Directed bench for inst_pos_bridge: misses, hits, flushes, range errors, backpressure, async reset.
// The timeout/DRAIN steps are included when INST_POS_BRIDGE_TIMEOUT_EN is defined.
module tb_inst_pos_bridge;

    logic        clk_i     = 1'b0;
    logic        rst_ni    = 1'b0;
    logic        req       = 1'b0;
    logic [31:0] addr      = 32'd0;
    logic        flush     = 1'b0;
    logic        ready     = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data  = 32'd0;
    logic        rsp_err   = 1'b0;

    logic        ack;
    logic [31:0] data;
    logic        err;
    logic        mem_valid;
    logic [31:0] mem_addr;

    int checks = 0;
    int errors = 0;

    inst_pos_bridge #(
        .ADDR_BASE      (32'h0000_0000),
        .ADDR_END       (32'h0000_0fff),
        .TIMEOUT_CYCLES (16'd4)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .inst_pos_req_i   (req),
        .inst_pos_addr_i  (addr),
        .inst_pos_ack_o   (ack),
        .inst_pos_data_o  (data),
        .inst_pos_error_o (err),
        .flush_i          (flush),
        .mem_req_valid_o  (mem_valid),
        .mem_req_ready_i  (ready),
        .mem_req_addr_o   (mem_addr),
        .mem_rsp_valid_i  (rsp_valid),
        .mem_rsp_data_i   (rsp_data),
        .mem_rsp_error_i  (rsp_err)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ack"}, ack, 32'd0);
        check({tag, " data"}, data, 32'd0);
        check({tag, " err"}, err, 32'd0);
        check({tag, " mem_valid"}, mem_valid, 32'd0);
        check({tag, " mem_addr"}, mem_addr, 32'd0);
    endtask

    // Miss: REQ for ready_delay+1 cycles, one WAIT cycle (plus one if flush_pre), then ACK.
    task automatic do_miss(input string tag, input logic [31:0] a, input int ready_delay,
                           input logic [31:0] d, input logic e,
                           input logic flush_pre, input logic flush_rsp);
        logic [31:0] aligned;
        aligned = {a[31:2], 2'b00};
        req  = 1'b1;
        addr = a;
        tick();
        for (int i = 0; i <= ready_delay; i++) begin
            check({tag, " req_valid"}, mem_valid, 32'd1);
            check({tag, " req_addr"}, mem_addr, aligned);
            check({tag, " no_ack_req"}, ack, 32'd0);
            if (i == ready_delay) ready = 1'b1;
            tick();
        end
        ready = 1'b0;
        check({tag, " wait_valid_low"}, mem_valid, 32'd0);
        if (flush_pre) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
            check({tag, " no_ack_flush"}, ack, 32'd0);
        end
        rsp_valid = 1'b1;
        rsp_data  = d;
        rsp_err   = e;
        flush     = flush_rsp;
        tick();
        rsp_valid = 1'b0;
        rsp_data  = 32'd0;
        rsp_err   = 1'b0;
        flush     = 1'b0;
        check({tag, " ack"}, ack, 32'd1);
        check({tag, " data"}, data, d);
        check({tag, " err"}, err, {31'd0, e});
        tick();
        req = 1'b0;
        check({tag, " ack_drop"}, ack, 32'd0);
    endtask

    // Hit or range error: ack in the cycle right after the request edge, no memory request.
    task automatic do_hit(input string tag, input logic [31:0] a,
                          input logic [31:0] d, input logic e);
        req  = 1'b1;
        addr = a;
        tick();
        check({tag, " ack"}, ack, 32'd1);
        check({tag, " data"}, data, d);
        check({tag, " err"}, err, {31'd0, e});
        check({tag, " no_mem_req"}, mem_valid, 32'd0);
        tick();
        req = 1'b0;
        check({tag, " ack_drop"}, ack, 32'd0);
        check({tag, " no_mem_req2"}, mem_valid, 32'd0);
    endtask

    initial begin
        #3;
        check_reset_outputs("reset");
        #9;
        rst_ni = 1'b1;
        tick();

        // Basic miss, minimum latency, then a same-word hit.
        do_miss("miss_100", 32'h0000_0100, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        do_hit("hit_102", 32'h0000_0102, 32'hDEAD_BEEF, 1'b0);

        // Idle flush forces a refetch.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        do_miss("refetch_100", 32'h0000_0100, 0, 32'h1111_2222, 1'b0, 1'b0, 1'b0);
        do_hit("hit_100", 32'h0000_0100, 32'h1111_2222, 1'b0);

        // Flush during WAIT: data is returned but not buffered.
        do_miss("wflush_200", 32'h0000_0200, 0, 32'hA5A5_0200, 1'b0, 1'b1, 1'b0);
        do_miss("remiss_200", 32'h0000_0200, 0, 32'h0200_B0B0, 1'b0, 1'b0, 1'b0);
        do_hit("hit_203", 32'h0000_0203, 32'h0200_B0B0, 1'b0);

        // Flush in the same cycle as the response write: the flush wins.
        do_miss("rflush_300", 32'h0000_0300, 0, 32'h0000_3333, 1'b0, 1'b0, 1'b1);
        do_miss("remiss_300", 32'h0000_0300, 0, 32'h3030_3030, 1'b0, 1'b0, 1'b0);
        do_hit("hit_300", 32'h0000_0300, 32'h3030_3030, 1'b0);

        // Range boundaries.
        do_hit("range_1000", 32'h0000_1000, 32'd0, 1'b1);
        do_hit("range_2000", 32'h0000_2000, 32'd0, 1'b1);
        do_miss("edge_ffc", 32'h0000_0ffc, 0, 32'h0FFC_0FFC, 1'b0, 1'b0, 1'b0);
        do_hit("edge_fff", 32'h0000_0fff, 32'h0FFC_0FFC, 1'b0);

        // Backpressure for 5 cycles, then an error response invalidates the buffer.
        do_miss("stall_400", 32'h0000_0400, 5, 32'h55AA_55AA, 1'b1, 1'b0, 1'b0);
        do_miss("inval_ffc", 32'h0000_0ffc, 0, 32'h0000_0001, 1'b0, 1'b0, 1'b0);

        // Async reset while the request is being presented.
        req  = 1'b1;
        addr = 32'h0000_0500;
        tick();
        check("rstreq valid_before", mem_valid, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("rst_in_req");
        req = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        rsp_valid = 1'b1;
        rsp_data  = 32'h0000_0BAD;
        tick();
        check("late_rsp ack", ack, 32'd0);
        check("late_rsp mem_valid", mem_valid, 32'd0);
        tick();
        rsp_valid = 1'b0;
        rsp_data  = 32'd0;
        check("late_rsp ack2", ack, 32'd0);

        // Async reset in WAIT.
        req   = 1'b1;
        addr  = 32'h0000_0600;
        ready = 1'b1;
        tick();
        tick();
        ready = 1'b0;
        check("rstwait valid_low", mem_valid, 32'd0);
        check("rstwait addr", mem_addr, 32'h0000_0600);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("rst_in_wait");
        req = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        do_miss("post_rst_ffc", 32'h0000_0ffc, 0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);

`ifdef INST_POS_BRIDGE_TIMEOUT_EN
        // Timeout after 4 WAIT cycles, late response dropped in DRAIN.
        req   = 1'b1;
        addr  = 32'h0000_0700;
        ready = 1'b1;
        tick();
        tick();
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to wait_no_ack", ack, 32'd0);
            tick();
        end
        check("to ack", ack, 32'd1);
        check("to err", err, 32'd1);
        check("to data", data, 32'd0);
        tick();
        req = 1'b0;
        check("drain ack", ack, 32'd0);
        tick();
        check("drain mem_valid", mem_valid, 32'd0);
        rsp_valid = 1'b1;
        rsp_data  = 32'h0000_1234;
        tick();
        rsp_valid = 1'b0;
        rsp_data  = 32'd0;
        check("drain discard ack", ack, 32'd0);
        do_miss("after_drain_800", 32'h0000_0800, 0, 32'h8888_8888, 1'b0, 1'b0, 1'b0);
        do_hit("hit_800", 32'h0000_0800, 32'h8888_8888, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
